// File: rtl/trans_mem_ctrl_pkg.sv
// Shared types and defaults for the transfer memory controller.
// Holds the FSM state encoding, default widths/latencies and the lane-count helper.
package trans_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBUSY = 2'd1,
        RBUSY = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_WR_LAT = 3;
    localparam int DEF_RD_LAT = 4;
    localparam int CNT_W      = 4;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/trans_mem_ctrl_bytemask_regfile.sv
// Byte-addressable word store: per-lane write enables, masked combinational read.
// The whole array clears synchronously on rst.
module trans_mem_ctrl_bytemask_regfile
    import trans_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W/8-1:0]    we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [ADDR_W-1:0]      raddr,
    input  logic [DATA_W/8-1:0]    rmask,
    output logic [DATA_W-1:0]      rdata
);

    localparam int LANES = lane_count(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rmask_bits_s;

    // Storage: clear on reset, otherwise update only enabled lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_r[w] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Expand the lane mask to bit granularity for the read port
    always_comb begin
        rmask_bits_s = '0;
        for (int i = 0; i < LANES; i++) begin
            rmask_bits_s[8*i +: 8] = {8{rmask[i]}};
        end
    end

    assign rdata = mem_r[raddr] & rmask_bits_s;

endmodule

// File: rtl/trans_mem_ctrl.sv
// Transfer controller: accepts one read or write strobe at a time from IDLE and
// completes it against the internal store after a fixed latency.
module trans_mem_ctrl
    import trans_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WR_LAT = DEF_WR_LAT,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_wr,
    input  logic                   cpu_rd,
    input  logic [DATA_W/8-1:0]    cpu_byte,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic                   cpu_rdata_v,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   trans_over
);

    localparam int LANES = lane_count(DATA_W);

    if (WR_LAT < 1 || WR_LAT > 15) begin : g_bad_wr_lat
        $error("trans_mem_ctrl: WR_LAT must be in 1..15");
    end
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("trans_mem_ctrl: RD_LAT must be in 1..15");
    end
    if (DATA_W != 8 * LANES || DATA_W < 8) begin : g_bad_data_w
        $error("trans_mem_ctrl: DATA_W must be a multiple of 8");
    end

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);

    state_t               state_r, next_state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [LANES-1:0]     byte_r;
    logic [DATA_W-1:0]    wdata_r;
    logic                 accept_s, done_s, rd_done_s;
    logic [LANES-1:0]     we_s;
    logic [DATA_W-1:0]    rf_rdata_s;

    trans_mem_ctrl_bytemask_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (addr_r),
        .wdata (wdata_r),
        .raddr (addr_r),
        .rmask (byte_r),
        .rdata (rf_rdata_s)
    );

    // Next-state logic; write takes priority when both strobes arrive together
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_wr) begin
                    next_state_s = WBUSY;
                    accept_s     = 1'b1;
                end else if (cpu_rd) begin
                    next_state_s = RBUSY;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WBUSY, RBUSY: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = IDLE;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        rd_done_s = done_s && (state_r == RBUSY);
        if (done_s && (state_r == WBUSY)) begin
            we_s = byte_r;
        end else begin
            we_s = '0;
        end
    end

    // State, counter, latched request fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= '0;
            byte_r      <= '0;
            wdata_r     <= '0;
            trans_over  <= 1'b1;
            cpu_rdata_v <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            state_r     <= next_state_s;
            trans_over  <= (next_state_s == IDLE);
            cpu_rdata_v <= rd_done_s;
            if (rd_done_s) begin
                cpu_rdata <= rf_rdata_s;
            end
            if (accept_s) begin
                addr_r  <= cpu_addr;
                byte_r  <= cpu_byte;
                wdata_r <= cpu_wdata;
                cnt_r   <= cpu_wr ? WR_LOAD : RD_LOAD;
            end else if (cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_trans_mem_ctrl.sv
// Self-checking bench for trans_mem_ctrl: directed steps plus randomized
// transfers checked against a transaction-level memory model.
module tb_trans_mem_ctrl;

    localparam int WR_LAT = 3;
    localparam int RD_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [3:0]  cpu_byte = 4'h0;
    logic [3:0]  cpu_addr = 4'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_rdata_v;
    logic [31:0] cpu_rdata;
    logic        trans_over;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_mem [16];
    logic [31:0] last_rdata;

    trans_mem_ctrl #(
        .DATA_W (32),
        .ADDR_W (4),
        .WR_LAT (WR_LAT),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wr      (cpu_wr),
        .cpu_rd      (cpu_rd),
        .cpu_byte    (cpu_byte),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata_v (cpu_rdata_v),
        .cpu_rdata   (cpu_rdata),
        .trans_over  (trans_over)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int w = 0; w < 16; w++) model_mem[w] = 32'h0;
        last_rdata = 32'h0;
    endtask

    // Starts and ends at a negedge of an idle cycle
    task automatic transfer(input logic wr, input logic rd, input logic [3:0] a,
                            input logic [3:0] be, input logic [31:0] d,
                            input int inj_cyc, input logic inj_wr, input logic inj_rd);
        int lat;
        logic [31:0] expv;
        lat = wr ? WR_LAT : RD_LAT;
        expv = 32'h0;
        cpu_wr = wr; cpu_rd = rd; cpu_addr = a; cpu_byte = be; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        cpu_addr = 4'($urandom); cpu_byte = 4'($urandom); cpu_wdata = $urandom;
        if (wr) begin
            model_mem[a] = (model_mem[a] & ~lane_mask(be)) | (d & lane_mask(be));
        end else begin
            expv = model_mem[a] & lane_mask(be);
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            check("busy_trans_over", {31'h0, trans_over}, 32'h0);
            check("busy_no_valid", {31'h0, cpu_rdata_v}, 32'h0);
            if (c == inj_cyc) begin
                cpu_wr = inj_wr; cpu_rd = inj_rd;
                cpu_addr = 4'($urandom); cpu_byte = 4'($urandom); cpu_wdata = $urandom;
                @(posedge clk); #1;
                cpu_wr = 1'b0; cpu_rd = 1'b0;
            end
        end
        @(negedge clk);
        check("done_trans_over", {31'h0, trans_over}, 32'h1);
        if (wr) begin
            check("wr_no_valid", {31'h0, cpu_rdata_v}, 32'h0);
            check("wr_rdata_hold", cpu_rdata, last_rdata);
        end else begin
            check("rd_valid", {31'h0, cpu_rdata_v}, 32'h1);
            check("rd_data", cpu_rdata, expv);
            last_rdata = expv;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("idle_trans_over", {31'h0, trans_over}, 32'h1);
            check("idle_no_valid", {31'h0, cpu_rdata_v}, 32'h0);
            check("idle_rdata_hold", cpu_rdata, last_rdata);
        end
    endtask

    initial begin
        // Reset for two cycles
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("rst_trans_over", {31'h0, trans_over}, 32'h1);
        check("rst_valid", {31'h0, cpu_rdata_v}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        transfer(1'b0, 1'b1, 4'd5, 4'hF, 32'h0, 0, 1'b0, 1'b0);

        // Full write then read-back
        transfer(1'b1, 1'b0, 4'd3, 4'hF, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        transfer(1'b0, 1'b1, 4'd3, 4'hF, 32'h0, 0, 1'b0, 1'b0);
        check("full_wr_value", cpu_rdata, 32'hDEADBEEF);

        // Partial lane write and masked read
        transfer(1'b1, 1'b0, 4'd3, 4'b0101, 32'h11223344, 0, 1'b0, 1'b0);
        transfer(1'b0, 1'b1, 4'd3, 4'hF, 32'h0, 0, 1'b0, 1'b0);
        check("partial_merge", cpu_rdata, 32'hDE22BE44);
        transfer(1'b0, 1'b1, 4'd3, 4'b1100, 32'h0, 0, 1'b0, 1'b0);
        check("masked_read", cpu_rdata, 32'hDE220000);

        // Strobe while busy is dropped
        transfer(1'b1, 1'b0, 4'd7, 4'hF, 32'hCAFEF00D, 2, 1'b1, 1'b0);
        transfer(1'b0, 1'b1, 4'd7, 4'hF, 32'h0, RD_LAT, 1'b1, 1'b1);
        check("busy_drop", cpu_rdata, 32'hCAFEF00D);

        // Simultaneous wr+rd: write wins
        transfer(1'b1, 1'b1, 4'd1, 4'hF, 32'h000000AA, 0, 1'b0, 1'b0);
        idle_cycles(2);
        transfer(1'b0, 1'b1, 4'd1, 4'hF, 32'h0, 0, 1'b0, 1'b0);
        check("wr_wins", cpu_rdata, 32'h000000AA);

        // Empty byte mask on write and read
        transfer(1'b1, 1'b0, 4'd1, 4'h0, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
        transfer(1'b0, 1'b1, 4'd1, 4'hF, 32'h0, 0, 1'b0, 1'b0);
        transfer(1'b0, 1'b1, 4'd7, 4'h0, 32'h0, 0, 1'b0, 1'b0);

        // Randomized traffic with busy-time noise and idle gaps
        for (int n = 0; n < 60; n++) begin
            logic w, r;
            w = 1'($urandom);
            r = w ? 1'($urandom) : 1'b1;
            transfer(w, r, 4'($urandom), 4'($urandom), $urandom,
                     int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // Make the store non-zero, then reset in the middle of a read
        transfer(1'b1, 1'b0, 4'd9, 4'hF, 32'hA5A5A5A5, 0, 1'b0, 1'b0);
        transfer(1'b0, 1'b1, 4'd9, 4'hF, 32'h0, 0, 1'b0, 1'b0);
        cpu_rd = 1'b1; cpu_addr = 4'd9; cpu_byte = 4'hF;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("midrst_trans_over", {31'h0, trans_over}, 32'h1);
        check("midrst_valid", {31'h0, cpu_rdata_v}, 32'h0);
        check("midrst_rdata", cpu_rdata, 32'h0);
        idle_cycles(4);
        for (int w = 0; w < 16; w++) begin
            transfer(1'b0, 1'b1, 4'(w), 4'hF, 32'h0, 0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
